// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder: behavioural stand-in for the SDRAM controller's
// user-side burst interface, backed by an on-chip 2^MEM_AW x 16 RAM.
//
// Handshake: a request (sdram_wr_req / sdram_rd_req) is a level that is
// sampled only while the FSM is IDLE. Once accepted, the address and length
// are latched. After REQ_LATENCY wait cycles the block pulses the matching
// ack once per word for exactly 'length' consecutive cycles:
//   - write: sys_data_in is consumed on every rising edge where sdram_wr_ack=1
//   - read:  sys_data_out holds the word belonging to the cycle where
//            sdram_rd_ack=1, and keeps its last value otherwise.
// A dropped request never aborts a burst in progress. Reset does.
module sdram_burst_responder #(
  parameter int INIT_CYCLES = 16,
  parameter int MEM_AW      = 10,
  parameter int REQ_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [22:0] sys_wraddr,
  input  logic [22:0] sys_rdaddr,
  input  logic [8:0]  sdwr_byte,
  input  logic [8:0]  sdrd_byte,
  input  logic [15:0] sys_data_in,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic [15:0] sys_data_out,
  output logic        sdram_init_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    WR_WAIT  = 3'd2,
    WR_BURST = 3'd3,
    RD_WAIT  = 3'd4,
    RD_BURST = 3'd5
  } state_e;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [3:0]  WAIT_LAST = 4'(REQ_LATENCY - 1);

  state_e              state_q, state_d;
  logic [15:0]         init_cnt_q, init_cnt_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [8:0]          len_q, len_d;
  logic                init_done_q, init_done_d;
  logic [15:0]         data_out_q, data_out_d;
  logic                rd_fetch;

  logic [15:0]         mem [2**MEM_AW];

  // Upper address bits are deliberately ignored; the RAM wraps.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^{sys_wraddr[22:MEM_AW], sys_rdaddr[22:MEM_AW]};

  // Acks are a pure decode of the registered state: one per remaining word.
  assign sdram_wr_ack    = (state_q == WR_BURST) && (len_q != 9'd0);
  assign sdram_rd_ack    = (state_q == RD_BURST) && (len_q != 9'd0);
  assign busy            = (state_q == WR_WAIT) || (state_q == WR_BURST) ||
                           (state_q == RD_WAIT) || (state_q == RD_BURST);
  assign sys_data_out    = data_out_q;
  assign sdram_init_done = init_done_q;

  // Next-state, latched burst context and read-fetch decisions.
  // len_q counts words still to be acked; in reads addr_q runs one word
  // ahead because each RAM read is launched the cycle before its ack.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    init_done_d = init_done_q;
    rd_fetch    = 1'b0;

    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 16'd1;
        end
      end
      IDLE: begin
        if (sdram_wr_req) begin
          state_d    = WR_WAIT;
          addr_d     = sys_wraddr[MEM_AW-1:0];
          len_d      = sdwr_byte;
          wait_cnt_d = 4'd0;
        end else if (sdram_rd_req) begin
          state_d    = RD_WAIT;
          addr_d     = sys_rdaddr[MEM_AW-1:0];
          len_d      = sdrd_byte;
          wait_cnt_d = 4'd0;
        end
      end
      WR_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = WR_BURST;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      WR_BURST: begin
        if (len_q == 9'd0) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
          len_d  = len_q - 9'd1;
          if (len_q == 9'd1) begin
            state_d = IDLE;
          end
        end
      end
      RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = RD_BURST;
          if (len_q != 9'd0) begin
            rd_fetch = 1'b1;
            addr_d   = addr_q + 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      RD_BURST: begin
        if (len_q == 9'd0) begin
          state_d = IDLE;
        end else begin
          len_d = len_q - 9'd1;
          if (len_q == 9'd1) begin
            state_d = IDLE;
          end else begin
            rd_fetch = 1'b1;
            addr_d   = addr_q + 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase

    data_out_d = rd_fetch ? mem[addr_q] : data_out_q;
  end

  // Control and read-data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_cnt_q  <= 16'd0;
      wait_cnt_q  <= 4'd0;
      addr_q      <= '0;
      len_q       <= 9'd0;
      init_done_q <= 1'b0;
      data_out_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      init_done_q <= init_done_d;
      data_out_q  <= data_out_d;
    end
  end

  // Backing store write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (sdram_wr_ack) begin
      mem[addr_q] <= sys_data_in;
    end
  end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder with a read-data scoreboard.
module tb_sdram_burst_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sdram_wr_req, sdram_rd_req;
  logic [22:0] sys_wraddr, sys_rdaddr;
  logic [8:0]  sdwr_byte, sdrd_byte;
  logic [15:0] sys_data_in;
  logic        sdram_wr_ack, sdram_rd_ack;
  logic [15:0] sys_data_out;
  logic        sdram_init_done, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int first_rd_cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_mem [1024];

  sdram_burst_responder #(
    .INIT_CYCLES(16), .MEM_AW(10), .REQ_LATENCY(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sys_wraddr(sys_wraddr), .sys_rdaddr(sys_rdaddr),
    .sdwr_byte(sdwr_byte), .sdrd_byte(sdrd_byte),
    .sys_data_in(sys_data_in),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sys_data_out(sys_data_out),
    .sdram_init_done(sdram_init_done), .busy(busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: scores read data against the expected queue, checks ack exclusivity
  always @(negedge clk) begin
    if (sdram_wr_ack || sdram_rd_ack)
      check("ack_exclusive", {31'd0, sdram_wr_ack & sdram_rd_ack}, 32'd0);
    if (sdram_rd_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got data %h with no expected word", sys_data_out);
      end else begin
        check("rd_data", {16'd0, sys_data_out}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Write driver: word k = base + k*step, supplied on each ack cycle.
  task automatic write_burst(input logic [22:0] addr, input int len,
                             input logic [15:0] base, input logic [15:0] step);
    int acks = 0;
    int bcyc = 0;
    int t = 0;
    bit seen = 0;
    bit done = 0;
    logic [9:0] a;
    sys_wraddr   = addr;
    sdwr_byte    = 9'(len);
    sys_data_in  = base;
    sdram_wr_req = 1'b1;
    while (t < 2000 && !done) begin
      @(negedge clk);
      t++;
      if (busy) begin
        bcyc++;
        seen = 1;
        sdram_wr_req = 1'b0;
      end else if (seen) begin
        done = 1;
      end
      if (sdram_wr_ack) begin
        a = addr[9:0] + 10'(acks);
        sys_data_in  = base + 16'(acks) * step;
        model_mem[a] = sys_data_in;
        acks++;
        last_wr_cyc = cyc;
      end
    end
    sdram_wr_req = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: burst at %h never finished", addr);
    end
    check("wr_ack_count", 32'(acks), 32'(len));
    check("wr_busy_cycles", 32'(bcyc), 32'(3 + ((len == 0) ? 1 : len)));
  endtask

  // Read driver: caller pushes expected words first; drops req on first ack.
  task automatic read_burst(input logic [22:0] addr, input int len);
    int got = 0;
    int t = 0;
    bit done = 0;
    sys_rdaddr   = addr;
    sdrd_byte    = 9'(len);
    sdram_rd_req = 1'b1;
    while (t < 2000 && !done) begin
      @(negedge clk);
      t++;
      if (sdram_rd_ack) begin
        got++;
        if (got == 1) begin
          sdram_rd_req = 1'b0;
          first_rd_cyc = cyc;
        end
      end
      if (got >= len && !busy && !sdram_rd_req) done = 1;
    end
    sdram_rd_req = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: burst at %h got %0d of %0d acks", addr, got, len);
    end
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_init();
    int t = 0;
    while (!sdram_init_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reinit_done", {31'd0, sdram_init_done}, 32'd1);
  endtask

  // Main directed sequence
  initial begin
    int early;
    int acks;
    int t;
    reset_n      = 1'b0;
    sdram_wr_req = 1'b1;
    sdram_rd_req = 1'b0;
    sys_wraddr   = 23'd5;
    sys_rdaddr   = 23'd0;
    sdwr_byte    = 9'd1;
    sdrd_byte    = 9'd0;
    sys_data_in  = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_init_done", {31'd0, sdram_init_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_ack", {31'd0, sdram_wr_ack}, 32'd0);
    check("rst_rd_ack", {31'd0, sdram_rd_ack}, 32'd0);
    check("rst_data_out", {16'd0, sys_data_out}, 32'd0);

    // Release reset with wr_req held: init after 16 edges, ack 4 cycles later
    reset_n = 1'b1;
    early = 0;
    repeat (15) begin
      @(negedge clk);
      if (sdram_wr_ack || busy) early++;
    end
    check("init_done_at_15", {31'd0, sdram_init_done}, 32'd0);
    check("no_activity_in_init", 32'(early), 32'd0);
    @(negedge clk);
    check("init_done_at_16", {31'd0, sdram_init_done}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (sdram_wr_ack) early++;
    end
    check("wait_no_ack", 32'(early), 32'd0);
    check("wait_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("first_wr_ack", {31'd0, sdram_wr_ack}, 32'd1);
    model_mem[5] = 16'h1234;
    sdram_wr_req = 1'b0;
    @(negedge clk);
    check("single_done_ack", {31'd0, sdram_wr_ack}, 32'd0);
    check("single_done_busy", {31'd0, busy}, 32'd0);

    // 256-word write then read
    write_burst(23'd0, 256, 16'd0, 16'd1);
    for (int k = 0; k < 256; k++) exp_q.push_back(16'(k));
    read_burst(23'd0, 256);
    @(negedge clk);
    check("data_out_hold", {16'd0, sys_data_out}, 32'd255);

    // Wrap at the top of the RAM; upper address bits ignored
    write_burst(23'd1022, 4, 16'hAAAA, 16'h1111);
    exp_q.push_back(16'hCCCC);
    exp_q.push_back(16'hDDDD);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd3);
    read_burst(23'd0, 4);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'hBBBB);
    read_burst(23'h7FFFFE, 2);

    // Simultaneous requests: write first, read after one IDLE cycle
    exp_q.push_back(16'hCCCC);
    exp_q.push_back(16'hDDDD);
    fork
      write_burst(23'd300, 3, 16'h7000, 16'd1);
      read_burst(23'd0, 2);
    join
    check("wr_then_rd_gap", 32'(first_rd_cyc - last_wr_cyc), 32'd5);
    exp_q.push_back(16'h7000);
    exp_q.push_back(16'h7001);
    exp_q.push_back(16'h7002);
    read_burst(23'd300, 3);

    // Zero-length burst: busy for 4 cycles, no acks
    write_burst(23'd400, 0, 16'hFFFF, 16'd0);

    // Reset during the 10th ack of a 100-word write
    sys_wraddr   = 23'd500;
    sdwr_byte    = 9'd100;
    sys_data_in  = 16'h5000;
    sdram_wr_req = 1'b1;
    acks = 0;
    t = 0;
    while (acks < 10 && t < 2000) begin
      @(negedge clk);
      t++;
      if (busy) sdram_wr_req = 1'b0;
      if (sdram_wr_ack) begin
        sys_data_in = 16'h5000 + 16'(acks);
        model_mem[10'd500 + 10'(acks)] = sys_data_in;
        acks++;
      end
    end
    check("pre_reset_acks", 32'(acks), 32'd10);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_wr_ack", {31'd0, sdram_wr_ack}, 32'd0);
    check("abort_init_done", {31'd0, sdram_init_done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data_out", {16'd0, sys_data_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    for (int k = 0; k < 10; k++) exp_q.push_back(model_mem[10'd500 + 10'(k)]);
    read_burst(23'd500, 10);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'hBBBB);
    read_burst(23'd1022, 2);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
